if_fetch: RTL and testbench

- Instruction-fetch request unit, directly downstream of the IF program-counter register.
- Takes the current PC, issues one instruction-memory request (valid/ready), and captures the response.
- Presents the instruction to the IF/ID boundary with a valid/ready handshake.
- Returns a one-cycle advance pulse that drives the PC register's instruction-valid input.
- Handles redirect flushes (jump/branch/trap) by killing in-flight or buffered fetches.
- Single outstanding request; no prefetch.

---
 rtl/if_fetch_pkg.sv | 10 +
 rtl/if_fetch_if.sv | 32 +++
 rtl/if_fetch.sv | 78 +++++++
 tb/tb_if_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, NOP encoding and fetch FSM state codes
package if_fetch_pkg;
    localparam int IF_ADDR_W = 64;
    localparam int IF_INST_W = 32;
    localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: PC, memory request/response and IF/ID handshake signals of the fetch unit
interface if_fetch_if #(
    parameter int ADDR_W = if_fetch_pkg::IF_ADDR_W,
    parameter int INST_W = if_fetch_pkg::IF_INST_W
);
    logic [ADDR_W-1:0] if_fetch_pc_i;
    logic              if_fetch_flush_i;
    logic              if_fetch_req_valid_o;
    logic              if_fetch_req_ready_i;
    logic [ADDR_W-1:0] if_fetch_req_addr_o;
    logic              if_fetch_rsp_valid_i;
    logic [INST_W-1:0] if_fetch_rsp_data_i;
    logic              if_fetch_rsp_err_i;
    logic              if_fetch_inst_valid_o;
    logic              if_fetch_inst_ready_i;
    logic [INST_W-1:0] if_fetch_inst_o;
    logic [ADDR_W-1:0] if_fetch_inst_addr_o;
    logic              if_fetch_inst_fault_o;
    logic              if_fetch_pc_advance_o;
    modport master (
        input  if_fetch_pc_i, if_fetch_flush_i, if_fetch_req_ready_i,
        input  if_fetch_rsp_valid_i, if_fetch_rsp_data_i, if_fetch_rsp_err_i, if_fetch_inst_ready_i,
        output if_fetch_req_valid_o, if_fetch_req_addr_o, if_fetch_inst_valid_o,
        output if_fetch_inst_o, if_fetch_inst_addr_o, if_fetch_inst_fault_o, if_fetch_pc_advance_o
    );
    modport slave (
        output if_fetch_pc_i, if_fetch_flush_i, if_fetch_req_ready_i,
        output if_fetch_rsp_valid_i, if_fetch_rsp_data_i, if_fetch_rsp_err_i, if_fetch_inst_ready_i,
        input  if_fetch_req_valid_o, if_fetch_req_addr_o, if_fetch_inst_valid_o,
        input  if_fetch_inst_o, if_fetch_inst_addr_o, if_fetch_inst_fault_o, if_fetch_pc_advance_o
    );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetch with redirect kill and IF/ID output hold
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int INST_W = IF_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(IF_NOP_INST)
) (
    input logic clk,
    input logic rst,
    if_fetch_if.master bus
);
    logic [1:0]        r_state;
    logic              r_kill;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_inst_addr;
    logic [INST_W-1:0] r_inst;
    logic              r_fault;
    logic              w_misaligned;
    logic              w_drop;

    assign w_misaligned = |bus.if_fetch_pc_i[1:0];
    assign w_drop       = r_kill | bus.if_fetch_flush_i;

    // FSM: latch PC, issue request, capture or discard response, hold until ID takes it or a redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_kill      <= 1'b0;
            r_addr      <= '0;
            r_inst_addr <= '0;
            r_inst      <= '0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr <= bus.if_fetch_pc_i;
                    if (w_misaligned) begin
                        r_state     <= S_HOLD;
                        r_inst      <= NOP_INST;
                        r_fault     <= 1'b1;
                        r_inst_addr <= bus.if_fetch_pc_i;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.if_fetch_flush_i) r_kill <= 1'b1;
                    if (bus.if_fetch_req_ready_i) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.if_fetch_rsp_valid_i && w_drop) begin
                        r_kill  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (bus.if_fetch_rsp_valid_i) begin
                        r_inst      <= bus.if_fetch_rsp_err_i ? NOP_INST : bus.if_fetch_rsp_data_i;
                        r_fault     <= bus.if_fetch_rsp_err_i;
                        r_inst_addr <= r_addr;
                        r_state     <= S_HOLD;
                    end else if (bus.if_fetch_flush_i) begin
                        r_kill <= 1'b1;
                    end
                end
                default: begin
                    if (bus.if_fetch_flush_i || bus.if_fetch_inst_ready_i) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_fetch_req_valid_o  = r_state == S_REQ;
    assign bus.if_fetch_req_addr_o   = r_addr;
    assign bus.if_fetch_inst_valid_o = r_state == S_HOLD;
    assign bus.if_fetch_inst_o       = r_inst;
    assign bus.if_fetch_inst_addr_o  = r_inst_addr;
    assign bus.if_fetch_inst_fault_o = r_fault;
    assign bus.if_fetch_pc_advance_o = (r_state == S_HOLD) & bus.if_fetch_inst_ready_i & ~bus.if_fetch_flush_i;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed table, corner-case sequences and a randomized scoreboard run for if_fetch
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        logic        err;
        logic [31:0] exp_inst;
        logic        exp_fault;
        logic        exp_req;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_if bus ();
    if_fetch dut (.clk(clk), .rst(rst), .bus(bus.master));

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic start(input logic [63:0] pc);
        bus.if_fetch_pc_i = pc;
        mid();
        chk("idle_outputs", {61'd0, bus.if_fetch_req_valid_o, bus.if_fetch_inst_valid_o, bus.if_fetch_pc_advance_o}, 64'd0);
    endtask

    task automatic hold_chk(input string n, input logic [31:0] inst, input logic [63:0] addr, input logic fault, input logic adv);
        chk({n, "_valid"}, 64'(bus.if_fetch_inst_valid_o), 64'd1);
        chk({n, "_inst"}, 64'(bus.if_fetch_inst_o), 64'(inst));
        chk({n, "_addr"}, bus.if_fetch_inst_addr_o, addr);
        chk({n, "_fault"}, 64'(bus.if_fetch_inst_fault_o), 64'(fault));
        chk({n, "_adv"}, 64'(bus.if_fetch_pc_advance_o), 64'(adv));
    endtask

    function automatic logic [31:0] mem_d(input logic [63:0] a);
        return a[31:0] * 32'h9E37_79B1 ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic mem_e(input logic [63:0] a);
        return a[5:2] == 4'hB;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        logic [63:0] pc_m, raddr, p_ra;
        logic [31:0] p_in;
        logic outst, busy, acc, p_rv, p_rr, p_iv, p_ir, p_fl;
        int cnt, stall, deliveries;
        vt[0] = '{64'h8000_0000, 32'h0000_0093, 1'b0, 32'h0000_0093, 1'b0, 1'b1};
        vt[1] = '{64'h8000_0004, 32'hDEAD_BEEF, 1'b1, NOP, 1'b1, 1'b1};
        vt[2] = '{64'h8000_0002, 32'h1111_1111, 1'b0, NOP, 1'b1, 1'b0};
        vt[3] = '{64'h8000_0001, 32'h2222_2222, 1'b0, NOP, 1'b1, 1'b0};
        vt[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vt[5] = '{64'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        bus.if_fetch_pc_i = '0;
        bus.if_fetch_flush_i = 1'b0;
        bus.if_fetch_req_ready_i = 1'b0;
        bus.if_fetch_rsp_valid_i = 1'b0;
        bus.if_fetch_rsp_data_i = '0;
        bus.if_fetch_rsp_err_i = 1'b0;
        bus.if_fetch_inst_ready_i = 1'b0;
        repeat (2) mid();
        chk("rst_req_valid", 64'(bus.if_fetch_req_valid_o), 64'd0);
        chk("rst_req_addr", bus.if_fetch_req_addr_o, 64'd0);
        chk("rst_inst_valid", 64'(bus.if_fetch_inst_valid_o), 64'd0);
        chk("rst_inst", 64'(bus.if_fetch_inst_o), 64'd0);
        chk("rst_inst_addr", bus.if_fetch_inst_addr_o, 64'd0);
        chk("rst_fault", 64'(bus.if_fetch_inst_fault_o), 64'd0);
        chk("rst_adv", 64'(bus.if_fetch_pc_advance_o), 64'd0);
        cyc();
        rst = 1'b0;
        // table: one full fetch per record, ready everywhere, 1-cycle memory
        for (int i = 0; i < 6; i++) begin
            bus.if_fetch_req_ready_i = 1'b1;
            bus.if_fetch_inst_ready_i = 1'b1;
            start(vt[i].pc);
            cyc();
            mid();
            if (vt[i].exp_req) begin
                chk("t1_req_valid", 64'(bus.if_fetch_req_valid_o), 64'd1);
                chk("t1_req_addr", bus.if_fetch_req_addr_o, vt[i].pc);
                chk("t1_no_adv", 64'(bus.if_fetch_pc_advance_o), 64'd0);
                cyc();
                bus.if_fetch_rsp_valid_i = 1'b1;
                bus.if_fetch_rsp_data_i = vt[i].data;
                bus.if_fetch_rsp_err_i = vt[i].err;
                mid();
                chk("t2_no_inst", 64'(bus.if_fetch_inst_valid_o), 64'd0);
                chk("t2_no_adv", 64'(bus.if_fetch_pc_advance_o), 64'd0);
                cyc();
                bus.if_fetch_rsp_valid_i = 1'b0;
                bus.if_fetch_rsp_err_i = 1'b0;
                mid();
            end else begin
                chk("misaligned_no_req", 64'(bus.if_fetch_req_valid_o), 64'd0);
            end
            hold_chk("tbl", vt[i].exp_inst, vt[i].pc, vt[i].exp_fault, 1'b1);
            cyc();
        end
        // backpressure on request then on ID
        bus.if_fetch_req_ready_i = 1'b0;
        bus.if_fetch_inst_ready_i = 1'b0;
        start(64'h8000_0010);
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.if_fetch_pc_i = 64'h8000_0F00 + 64'(k * 4);
            mid();
            chk("bp_req_valid", 64'(bus.if_fetch_req_valid_o), 64'd1);
            chk("bp_req_addr", bus.if_fetch_req_addr_o, 64'h8000_0010);
        end
        cyc();
        bus.if_fetch_req_ready_i = 1'b1;
        mid();
        chk("bp_req_addr_acc", bus.if_fetch_req_addr_o, 64'h8000_0010);
        cyc();
        bus.if_fetch_req_ready_i = 1'b0;
        bus.if_fetch_rsp_valid_i = 1'b1;
        bus.if_fetch_rsp_data_i = 32'h1234_5678;
        mid();
        chk("bp_wait_no_req", 64'(bus.if_fetch_req_valid_o), 64'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            bus.if_fetch_rsp_valid_i = 1'b0;
            mid();
            hold_chk("bp_hold", 32'h1234_5678, 64'h8000_0010, 1'b0, 1'b0);
        end
        cyc();
        bus.if_fetch_inst_ready_i = 1'b1;
        mid();
        hold_chk("bp_accept", 32'h1234_5678, 64'h8000_0010, 1'b0, 1'b1);
        cyc();
        // flush while waiting for the response
        bus.if_fetch_req_ready_i = 1'b1;
        start(64'h8000_0020);
        cyc();
        mid();
        chk("fw_req_addr", bus.if_fetch_req_addr_o, 64'h8000_0020);
        cyc();
        bus.if_fetch_flush_i = 1'b1;
        mid();
        chk("fw_wait", 64'({bus.if_fetch_req_valid_o, bus.if_fetch_inst_valid_o}), 64'd0);
        cyc();
        bus.if_fetch_flush_i = 1'b0;
        bus.if_fetch_pc_i = 64'h8000_0100;
        mid();
        chk("fw_no_inst_a", 64'(bus.if_fetch_inst_valid_o), 64'd0);
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b1;
        bus.if_fetch_rsp_data_i = 32'hDEAD_BEEF;
        mid();
        chk("fw_no_inst_b", 64'({bus.if_fetch_inst_valid_o, bus.if_fetch_pc_advance_o}), 64'd0);
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b0;
        mid();
        chk("fw_idle", 64'({bus.if_fetch_inst_valid_o, bus.if_fetch_req_valid_o}), 64'd0);
        cyc();
        mid();
        chk("fw_new_req", 64'(bus.if_fetch_req_valid_o), 64'd1);
        chk("fw_new_addr", bus.if_fetch_req_addr_o, 64'h8000_0100);
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b1;
        bus.if_fetch_rsp_data_i = 32'h0000_0033;
        mid();
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b0;
        mid();
        hold_chk("fw_after", 32'h0000_0033, 64'h8000_0100, 1'b0, 1'b1);
        cyc();
        // flush and ready together in HOLD
        start(64'h8000_0200);
        cyc();
        mid();
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b1;
        bus.if_fetch_rsp_data_i = 32'h0000_0044;
        mid();
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b0;
        bus.if_fetch_flush_i = 1'b1;
        mid();
        hold_chk("fh_hold", 32'h0000_0044, 64'h8000_0200, 1'b0, 1'b0);
        cyc();
        bus.if_fetch_flush_i = 1'b0;
        bus.if_fetch_pc_i = 64'h8000_0300;
        mid();
        chk("fh_dropped", 64'({bus.if_fetch_inst_valid_o, bus.if_fetch_req_valid_o}), 64'd0);
        cyc();
        mid();
        chk("fh_new_addr", bus.if_fetch_req_addr_o, 64'h8000_0300);
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b1;
        bus.if_fetch_rsp_data_i = 32'h0000_0055;
        mid();
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b0;
        mid();
        hold_chk("fh_after", 32'h0000_0055, 64'h8000_0300, 1'b0, 1'b1);
        cyc();
        // asynchronous reset in WAIT, stale response afterwards
        start(64'h8000_0400);
        cyc();
        mid();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req_valid", 64'(bus.if_fetch_req_valid_o), 64'd0);
        chk("ar_req_addr", bus.if_fetch_req_addr_o, 64'd0);
        chk("ar_inst", 64'({bus.if_fetch_inst_valid_o, bus.if_fetch_inst_o}), 64'd0);
        chk("ar_inst_addr", bus.if_fetch_inst_addr_o, 64'd0);
        chk("ar_fault_adv", 64'({bus.if_fetch_inst_fault_o, bus.if_fetch_pc_advance_o}), 64'd0);
        cyc();
        rst = 1'b0;
        bus.if_fetch_pc_i = 64'h8000_0500;
        bus.if_fetch_rsp_valid_i = 1'b1;
        bus.if_fetch_rsp_data_i = 32'hDEAD_BEEF;
        mid();
        chk("ar_stale_idle", 64'({bus.if_fetch_inst_valid_o, bus.if_fetch_req_valid_o}), 64'd0);
        cyc();
        bus.if_fetch_req_ready_i = 1'b0;
        mid();
        chk("ar_fresh_req", 64'(bus.if_fetch_req_valid_o), 64'd1);
        chk("ar_fresh_addr", bus.if_fetch_req_addr_o, 64'h8000_0500);
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b0;
        bus.if_fetch_req_ready_i = 1'b1;
        mid();
        chk("ar_still_req", 64'({bus.if_fetch_req_valid_o, bus.if_fetch_inst_valid_o}), 64'd2);
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b1;
        bus.if_fetch_rsp_data_i = 32'h0000_0066;
        mid();
        cyc();
        bus.if_fetch_rsp_valid_i = 1'b0;
        mid();
        hold_chk("ar_after", 32'h0000_0066, 64'h8000_0500, 1'b0, 1'b1);
        cyc();
        // randomized run against a transaction-level scoreboard
        pc_m = 64'h8000_1000;
        outst = 1'b0;
        cnt = 0;
        raddr = '0;
        stall = 0;
        deliveries = 0;
        {p_rv, p_rr, p_iv, p_ir, p_fl} = '0;
        p_ra = '0;
        p_in = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) cyc();
            if (outst && cnt == 0) begin
                bus.if_fetch_rsp_valid_i = 1'b1;
                bus.if_fetch_rsp_data_i = mem_d(raddr);
                bus.if_fetch_rsp_err_i = mem_e(raddr);
            end else begin
                bus.if_fetch_rsp_valid_i = !outst && $urandom_range(0, 7) == 0;
                bus.if_fetch_rsp_data_i = $urandom;
                bus.if_fetch_rsp_err_i = 1'($urandom_range(0, 1));
            end
            busy = bus.if_fetch_req_valid_o | bus.if_fetch_inst_valid_o | outst;
            bus.if_fetch_flush_i = busy && $urandom_range(0, 9) == 0;
            bus.if_fetch_req_ready_i = $urandom_range(0, 2) != 0;
            bus.if_fetch_inst_ready_i = $urandom_range(0, 2) != 0;
            bus.if_fetch_pc_i = pc_m;
            mid();
            acc = bus.if_fetch_inst_valid_o & bus.if_fetch_inst_ready_i & ~bus.if_fetch_flush_i;
            chk("rnd_adv", 64'(bus.if_fetch_pc_advance_o), 64'(acc));
            if (bus.if_fetch_req_valid_o) begin
                chk("rnd_req_align", 64'(bus.if_fetch_req_addr_o[1:0]), 64'd0);
                chk("rnd_single_outstanding", 64'(outst), 64'd0);
            end
            if (p_rv && !p_rr) begin
                chk("rnd_req_held", 64'(bus.if_fetch_req_valid_o), 64'd1);
                chk("rnd_req_addr_stable", bus.if_fetch_req_addr_o, p_ra);
            end
            if (p_iv && !p_ir && !p_fl) begin
                chk("rnd_inst_held", 64'(bus.if_fetch_inst_valid_o), 64'd1);
                chk("rnd_inst_stable", 64'(bus.if_fetch_inst_o), 64'(p_in));
            end
            if (acc) begin
                deliveries++;
                chk("rnd_inst_addr", bus.if_fetch_inst_addr_o, pc_m);
                if (pc_m[1:0] != 2'b00) begin
                    chk("rnd_mis_inst", 64'(bus.if_fetch_inst_o), 64'(NOP));
                    chk("rnd_mis_fault", 64'(bus.if_fetch_inst_fault_o), 64'd1);
                end else begin
                    chk("rnd_inst", 64'(bus.if_fetch_inst_o), 64'(mem_e(pc_m) ? NOP : mem_d(pc_m)));
                    chk("rnd_fault", 64'(bus.if_fetch_inst_fault_o), 64'(mem_e(pc_m)));
                end
            end
            {p_rv, p_rr, p_iv, p_ir, p_fl} = {bus.if_fetch_req_valid_o, bus.if_fetch_req_ready_i,
                bus.if_fetch_inst_valid_o, bus.if_fetch_inst_ready_i, bus.if_fetch_flush_i};
            p_ra = bus.if_fetch_req_addr_o;
            p_in = bus.if_fetch_inst_o;
            if (outst && bus.if_fetch_rsp_valid_i) outst = 1'b0;
            else if (outst) cnt--;
            if (bus.if_fetch_req_valid_o && bus.if_fetch_req_ready_i) begin
                outst = 1'b1;
                cnt = $urandom_range(0, 3);
                raddr = bus.if_fetch_req_addr_o;
            end
            if (bus.if_fetch_flush_i)
                pc_m = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4 + ($urandom_range(0, 7) == 0 ? 64'($urandom_range(1, 3)) : 64'd0);
            else if (acc)
                pc_m = pc_m + 64'd4;
            stall = (acc || bus.if_fetch_flush_i) ? 0 : stall + 1;
            if (stall > 60) begin
                chk("rnd_progress_timeout", 64'(stall), 64'd0);
                break;
            end
        end
        chk("rnd_deliveries", 64'(deliveries >= 50), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
